// File: rtl/peripheral_timer_responder.sv
// Memory-mapped timer / LED / 7-segment / switch peripheral on the CPU data bus.
// Loads return data combinationally in the same MEM cycle. Stores commit on the rising edge.
// irq is built only from register state, so the bus has no combinational path to it.
module peripheral_timer_responder #(
    parameter logic [31:0] BASE_ADDR = 32'h4000_0000,
    parameter int unsigned LED_W     = 8,
    parameter int unsigned DIG_W     = 12,
    parameter int unsigned SW_W      = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             MemRead,
    input  logic             MemWrite,
    input  logic [31:0]      Address,
    input  logic [31:0]      Write_data,
    output logic [31:0]      Read_data,
    input  logic [SW_W-1:0]  switches,
    output logic [LED_W-1:0] leds,
    output logic [DIG_W-1:0] digits,
    output logic             irq
);

    localparam int unsigned DATA_W = 32;
    localparam int unsigned TCON_W = 3;
    localparam int unsigned SEL_W  = 3;

    localparam logic [SEL_W-1:0] OFS_TH      = 3'd0;
    localparam logic [SEL_W-1:0] OFS_TL      = 3'd1;
    localparam logic [SEL_W-1:0] OFS_TCON    = 3'd2;
    localparam logic [SEL_W-1:0] OFS_LED     = 3'd3;
    localparam logic [SEL_W-1:0] OFS_SWITCH  = 3'd4;
    localparam logic [SEL_W-1:0] OFS_DIGITS  = 3'd5;
    localparam logic [SEL_W-1:0] OFS_SYSTICK = 3'd6;
    localparam logic [SEL_W-1:0] OFS_NONE    = 3'd7;

    // TCON bit positions
    localparam int unsigned TCON_EN  = 0;
    localparam int unsigned TCON_IE  = 1;
    localparam int unsigned TCON_IST = 2;

    logic [DATA_W-1:0] th_q;
    logic [DATA_W-1:0] tl_q;
    logic [DATA_W-1:0] tl_d;
    logic [TCON_W-1:0] tcon_q;
    logic [TCON_W-1:0] tcon_d;
    logic [LED_W-1:0]  led_q;
    logic [DIG_W-1:0]  dig_q;
    logic [DATA_W-1:0] systick_q;
    logic [SW_W-1:0]   sw_meta_q;
    logic [SW_W-1:0]   sw_sync_q;

    logic [SEL_W-1:0]  sel;
    logic              hit;
    logic              wr_en;
    logic              ovf;
    logic              ovf_set;
    logic [DATA_W-1:0] rdata_c;
    logic              unused_addr_lsb;

    // Byte lane bits are not decoded; word accesses only.
    assign unused_addr_lsb = ^Address[1:0];

    // Window and offset decode; offset 0x1C is unmapped.
    assign sel   = Address[4:2];
    assign hit   = (Address[31:5] == BASE_ADDR[31:5]) && (sel != OFS_NONE);
    assign wr_en = MemWrite && hit;

    // Timer overflow this cycle and whether it raises status.
    assign ovf     = tcon_q[TCON_EN] && (tl_q == '1);
    assign ovf_set = ovf && tcon_q[TCON_IE];

    // Next TL / TCON: a CPU write beats the counter, but an overflow never drops status.
    always_comb begin
        tl_d   = tl_q;
        tcon_d = tcon_q;
        if (tcon_q[TCON_EN]) begin
            tl_d = ovf ? th_q : (tl_q + 32'd1);
        end
        tcon_d[TCON_IST] = tcon_q[TCON_IST] | ovf_set;
        if (wr_en && (sel == OFS_TL)) begin
            tl_d = Write_data;
        end
        if (wr_en && (sel == OFS_TCON)) begin
            tcon_d = {Write_data[TCON_IST] | ovf_set, Write_data[TCON_IE:TCON_EN]};
        end
    end

    // Timer registers and free-running system tick.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            th_q      <= '0;
            tl_q      <= '0;
            tcon_q    <= '0;
            systick_q <= '0;
        end else begin
            if (wr_en && (sel == OFS_TH)) begin
                th_q <= Write_data;
            end
            tl_q      <= tl_d;
            tcon_q    <= tcon_d;
            systick_q <= systick_q + 32'd1;
        end
    end

    // LED and 7-segment output registers; upper write bits are dropped.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            led_q <= '0;
            dig_q <= '0;
        end else begin
            if (wr_en && (sel == OFS_LED)) begin
                led_q <= Write_data[LED_W-1:0];
            end
            if (wr_en && (sel == OFS_DIGITS)) begin
                dig_q <= Write_data[DIG_W-1:0];
            end
        end
    end

    // Two-flop synchroniser for the asynchronous board switches.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sw_meta_q <= '0;
            sw_sync_q <= '0;
        end else begin
            sw_meta_q <= switches;
            sw_sync_q <= sw_meta_q;
        end
    end

    // Zero-latency load mux; shows pre-write state when a store is in the same cycle.
    always_comb begin
        rdata_c = '0;
        if (MemRead && hit) begin
            case (sel)
                OFS_TH:      rdata_c = th_q;
                OFS_TL:      rdata_c = tl_q;
                OFS_TCON:    rdata_c = DATA_W'(tcon_q);
                OFS_LED:     rdata_c = DATA_W'(led_q);
                OFS_SWITCH:  rdata_c = DATA_W'(sw_sync_q);
                OFS_DIGITS:  rdata_c = DATA_W'(dig_q);
                OFS_SYSTICK: rdata_c = systick_q;
                default:     rdata_c = '0;
            endcase
        end
    end

    assign Read_data = rdata_c;
    assign leds      = led_q;
    assign digits    = dig_q;
    assign irq       = tcon_q[TCON_IE] & tcon_q[TCON_IST];

endmodule

// File: tb/tb_peripheral_timer_responder.sv
// Directed bench for peripheral_timer_responder with hand-computed expectations.
module tb_peripheral_timer_responder;

    localparam logic [31:0] A_TH   = 32'h4000_0000;
    localparam logic [31:0] A_TL   = 32'h4000_0004;
    localparam logic [31:0] A_TCON = 32'h4000_0008;
    localparam logic [31:0] A_LED  = 32'h4000_000C;
    localparam logic [31:0] A_SW   = 32'h4000_0010;
    localparam logic [31:0] A_DIG  = 32'h4000_0014;
    localparam logic [31:0] A_TICK = 32'h4000_0018;

    logic        clk;
    logic        reset;
    logic        MemRead;
    logic        MemWrite;
    logic [31:0] Address;
    logic [31:0] Write_data;
    logic [31:0] Read_data;
    logic [7:0]  switches;
    logic [7:0]  leds;
    logic [11:0] digits;
    logic        irq;

    int unsigned total;
    int unsigned bad;
    logic [31:0] rdat;

    peripheral_timer_responder dut (
        .clk        (clk),
        .reset      (reset),
        .MemRead    (MemRead),
        .MemWrite   (MemWrite),
        .Address    (Address),
        .Write_data (Write_data),
        .Read_data  (Read_data),
        .switches   (switches),
        .leds       (leds),
        .digits     (digits),
        .irq        (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%08h want=%08h", tag, got, exp);
        end
    endtask

    // One bus access: drive at negedge, sample load data before the rising edge.
    task automatic bus_op(input logic rd, input logic wr, input logic [31:0] addr,
                          input logic [31:0] wdata, output logic [31:0] rd_out);
        @(negedge clk);
        MemRead    = rd;
        MemWrite   = wr;
        Address    = addr;
        Write_data = wdata;
        #1 rd_out = Read_data;
        @(posedge clk);
        #1;
        MemRead  = 1'b0;
        MemWrite = 1'b0;
    endtask

    task automatic bus_wr(input logic [31:0] addr, input logic [31:0] wdata);
        logic [31:0] dummy;
        bus_op(1'b0, 1'b1, addr, wdata, dummy);
    endtask

    task automatic bus_rd(input logic [31:0] addr, output logic [31:0] rd_out);
        bus_op(1'b1, 1'b0, addr, 32'h0, rd_out);
    endtask

    initial begin
        logic [31:0] addrs [7];
        total      = 0;
        bad        = 0;
        reset      = 1'b1;
        MemRead    = 1'b0;
        MemWrite   = 1'b0;
        Address    = 32'h0;
        Write_data = 32'h0;
        switches   = 8'h00;
        addrs = '{A_TH, A_TL, A_TCON, A_LED, A_SW, A_DIG, A_TICK};

        // Reset state: every offset reads zero while reset is held
        repeat (2) @(negedge clk);
        MemRead = 1'b1;
        for (int i = 0; i < 7; i++) begin
            Address = addrs[i];
            #1 chk($sformatf("rst_rd%0d", i), Read_data, 32'h0);
        end
        MemRead = 1'b0;
        chk("rst_irq", 32'(irq), 32'h0);
        chk("rst_leds", 32'(leds), 32'h0);
        chk("rst_digits", 32'(digits), 32'h0);
        @(negedge clk);
        reset = 1'b0;

        // SYSTICK: one rising edge since reset release
        bus_rd(A_TICK, rdat);
        chk("tick1", rdat, 32'h1);
        bus_rd(A_TICK, rdat);
        chk("tick2", rdat, 32'h2);

        // Timer overflow and reload
        bus_wr(A_TH, 32'hFFFF_FFFA);
        bus_wr(A_TL, 32'hFFFF_FFFD);
        bus_wr(A_TCON, 32'h3);
        bus_rd(A_TL, rdat);
        chk("tl_fd", rdat, 32'hFFFF_FFFD);
        bus_rd(A_TL, rdat);
        chk("tl_fe", rdat, 32'hFFFF_FFFE);
        chk("irq_pre", 32'(irq), 32'h0);
        bus_rd(A_TL, rdat);
        chk("tl_ff", rdat, 32'hFFFF_FFFF);
        chk("irq_set", 32'(irq), 32'h1);
        bus_rd(A_TL, rdat);
        chk("tl_reload", rdat, 32'hFFFF_FFFA);
        bus_rd(A_TCON, rdat);
        chk("tcon_7", rdat, 32'h7);

        // Clear status in a non-overflow cycle, then collide a TCON write with an overflow
        bus_wr(A_TH, 32'hFFFF_FFFF);
        bus_wr(A_TCON, 32'h3);
        chk("irq_clr", 32'(irq), 32'h0);
        bus_op(1'b1, 1'b1, A_TL, 32'hFFFF_FFFF, rdat);
        chk("tl_running_rw", rdat, 32'hFFFF_FFFE);
        chk("irq_still_clr", 32'(irq), 32'h0);
        bus_wr(A_TCON, 32'h3);
        chk("irq_ovf_kept", 32'(irq), 32'h1);
        bus_rd(A_TL, rdat);
        chk("tl_th_ff", rdat, 32'hFFFF_FFFF);
        bus_wr(A_TCON, 32'h0);
        bus_rd(A_TCON, rdat);
        chk("tcon_ovf_dis", rdat, 32'h4);
        chk("irq_ie_off", 32'(irq), 32'h0);
        bus_wr(A_TCON, 32'h0);
        bus_rd(A_TCON, rdat);
        chk("tcon_zero", rdat, 32'h0);
        bus_rd(A_TL, rdat);
        chk("tl_frozen", rdat, 32'hFFFF_FFFF);

        // LED / DIGITS / SWITCH
        bus_op(1'b1, 1'b1, A_LED, 32'h0000_01A5, rdat);
        chk("led_prewrite", rdat, 32'h0);
        chk("leds", 32'(leds), 32'hA5);
        bus_rd(A_LED, rdat);
        chk("led_rd", rdat, 32'hA5);
        bus_rd(32'h4000_000D, rdat);
        chk("led_byteaddr", rdat, 32'hA5);
        bus_wr(A_DIG, 32'hFFFF_0E3C);
        chk("digits", 32'(digits), 32'hE3C);
        bus_rd(A_DIG, rdat);
        chk("dig_rd", rdat, 32'hE3C);
        bus_wr(A_SW, 32'hFFFF_FFFF);
        bus_rd(A_SW, rdat);
        chk("sw_ro", rdat, 32'h0);
        @(negedge clk);
        switches = 8'h5C;
        @(posedge clk);
        @(posedge clk);
        bus_rd(A_SW, rdat);
        chk("sw_sync", rdat, 32'h5C);
        bus_rd(32'h4000_0020, rdat);
        chk("rd_above", rdat, 32'h0);
        bus_rd(32'h3FFF_FFFC, rdat);
        chk("rd_below", rdat, 32'h0);
        bus_rd(32'h4000_001C, rdat);
        chk("rd_1c", rdat, 32'h0);

        // Asynchronous reset mid-count
        bus_wr(A_TL, 32'h1234_5678);
        bus_wr(A_TCON, 32'h7);
        chk("irq_before_rst", 32'(irq), 32'h1);
        #2 reset = 1'b1;
        #1 chk("arst_irq", 32'(irq), 32'h0);
        MemRead = 1'b1;
        Address = A_TL;
        #1 chk("arst_tl", Read_data, 32'h0);
        Address = A_TCON;
        #1 chk("arst_tcon", Read_data, 32'h0);
        Address = A_TICK;
        #1 chk("arst_tick", Read_data, 32'h0);
        MemRead = 1'b0;
        chk("arst_leds", 32'(leds), 32'h0);
        chk("arst_digits", 32'(digits), 32'h0);
        @(negedge clk);
        reset = 1'b0;
        repeat (2) @(posedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
